// File: rtl/order_pkg.sv
// Shared definitions for the insertion-sorting stream block: compare modes, FSM states and
// the binary64 total-order key mapping.
package order_pkg;

    localparam int unsigned MODE_UNSIGNED = 0;
    localparam int unsigned MODE_SIGNED   = 1;
    localparam int unsigned MODE_FLOAT64  = 2;

    typedef enum logic {
        StFill,
        StDrain
    } state_t;

    // Negative values invert fully and positive values flip the sign bit, which turns the
    // binary64 total order into a plain unsigned order.
    function automatic logic [63:0] float64_key(input logic [63:0] k);
        return k[63] ? ~k : (k ^ 64'h8000_0000_0000_0000);
    endfunction

endpackage

// File: rtl/order_less_than.sv
// Combinational lt(a, b) for one slot, in unsigned, signed or binary64 total-order mode.
module order_less_than
    import order_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned MODE  = MODE_FLOAT64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt
);

    if (MODE == MODE_FLOAT64) begin : g_float
        assign lt = float64_key(a[63:0]) < float64_key(b[63:0]);
    end else if (MODE == MODE_SIGNED) begin : g_signed
        assign lt = $signed(a) < $signed(b);
    end else begin : g_unsigned
        assign lt = a < b;
    end

endmodule

// File: rtl/order_stream_sorter.sv
// Collects a frame of up to DEPTH values, insertion-sorting each one as it arrives, then
// streams the sorted frame out.
module order_stream_sorter
    import order_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned MODE  = MODE_FLOAT64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         descend,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   frame_count
);

    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam int unsigned   IW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [WIDTH-1:0] slot_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    ins_pos;
    logic             dir_q, dir_d, dir_eff;
    logic [DEPTH-1:0] before_slot;
    logic             accept, emit;

    // The first value of a frame must already see the new direction.
    assign dir_eff = (count_q == '0) ? descend : dir_q;
    assign accept  = in_valid && in_ready;
    assign emit    = out_valid && out_ready;

    // before_slot[k] = before(in_data, S[k]); descending swaps the comparator operands.
    for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
        order_less_than #(
            .WIDTH (WIDTH),
            .MODE  (MODE)
        ) u_lt (
            .a  (dir_eff ? slot_q[k] : in_data),
            .b  (dir_eff ? in_data : slot_q[k]),
            .lt (before_slot[k])
        );
    end

    // Counting every slot the new value does not precede keeps equal keys in arrival order.
    always_comb begin
        ins_pos = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count_q) && !before_slot[k]) begin
                ins_pos = ins_pos + CW'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        dir_d    = dir_q;
        slot_d   = slot_q;
        unique case (state_q)
            StFill: begin
                if (accept) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        if (CW'(k) < ins_pos) begin
                            slot_d[k] = slot_q[k];
                        end else if (CW'(k) == ins_pos) begin
                            slot_d[k] = in_data;
                        end else begin
                            slot_d[k] = slot_q[(k == 0) ? 0 : k - 1];
                        end
                    end
                    count_d = count_q + CW'(1);
                    if (count_q == '0) begin
                        dir_d = descend;
                    end
                    if (in_last || (count_d == DEPTH_C)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (emit) begin
                    if (out_last) begin
                        state_d  = StFill;
                        count_d  = '0;
                        rd_ptr_d = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + CW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StFill;
            count_q  <= '0;
            rd_ptr_q <= '0;
            dir_q    <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            dir_q    <= dir_d;
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    always_comb begin
        in_ready    = (state_q == StFill);
        out_valid   = (state_q == StDrain);
        out_data    = out_valid ? slot_q[rd_ptr_q[IW-1:0]] : '0;
        out_last    = out_valid && (rd_ptr_q == (count_q - CW'(1)));
        frame_count = count_q;
    end

endmodule

// File: tb/tb_order_stream_sorter.sv
// Directed bench: three sorters (unsigned, signed, binary64) share one input stream and one
// out_ready, so they stay in lockstep; each test checks the instance whose mode it targets.
module tb_order_stream_sorter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        descend = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready [3];
    logic        out_valid [3];
    logic [63:0] out_data [3];
    logic        out_last [3];
    logic [3:0]  frame_count [3];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    order_stream_sorter #(.WIDTH(64), .DEPTH(8), .MODE(0)) u_uns (
        .clock       (clock),
        .reset       (reset),
        .descend     (descend),
        .in_valid    (in_valid),
        .in_ready    (in_ready[0]),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid[0]),
        .out_ready   (out_ready),
        .out_data    (out_data[0]),
        .out_last    (out_last[0]),
        .frame_count (frame_count[0])
    );

    order_stream_sorter #(.WIDTH(64), .DEPTH(8), .MODE(1)) u_sgn (
        .clock       (clock),
        .reset       (reset),
        .descend     (descend),
        .in_valid    (in_valid),
        .in_ready    (in_ready[1]),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid[1]),
        .out_ready   (out_ready),
        .out_data    (out_data[1]),
        .out_last    (out_last[1]),
        .frame_count (frame_count[1])
    );

    order_stream_sorter #(.WIDTH(64), .DEPTH(8), .MODE(2)) u_flt (
        .clock       (clock),
        .reset       (reset),
        .descend     (descend),
        .in_valid    (in_valid),
        .in_ready    (in_ready[2]),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid[2]),
        .out_ready   (out_ready),
        .out_data    (out_data[2]),
        .out_last    (out_last[2]),
        .frame_count (frame_count[2])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one value; it is accepted at the next rising edge.
    task automatic send(input logic [63:0] v, input logic last);
        chk("in_ready_fill", 64'(in_ready[0]), 64'd1);
        in_valid = 1'b1;
        in_data  = v;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv(input int idx, input logic [63:0] exp, input logic exp_last,
                        input string tag);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!out_valid[idx] && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 64'(out_valid[idx]), 64'd1);
        chk({tag, "_data"}, out_data[idx], exp);
        chk({tag, "_last"}, 64'(out_last[idx]), 64'(exp_last));
        tick();
    endtask

    // One DRAIN cycle of the unsigned instance with a chosen out_ready.
    task automatic step(input logic rdy, input logic [63:0] exp, input logic exp_last);
        out_ready = rdy;
        chk("bp_valid", 64'(out_valid[0]), 64'd1);
        chk("bp_data", out_data[0], exp);
        chk("bp_last", 64'(out_last[0]), 64'(exp_last));
        chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
        tick();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready[0]), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid[0]), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last[0]), 64'd0);
        chk({tag, "_out_data"}, out_data[0], 64'd0);
        chk({tag, "_frame_count"}, 64'(frame_count[0]), 64'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        check_idle("rst_async");
        @(negedge clock);
        reset = 1'b1;
        tick();
        check_idle("rst_after");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check_idle("reset");
        @(negedge clock);
        reset = 1'b1;
        tick();

        // Unsigned ascending, full frame closes on the 8th value.
        descend = 1'b0;
        send(64'd5, 1'b0); send(64'd3, 1'b0); send(64'd9, 1'b0); send(64'd1, 1'b0);
        send(64'd7, 1'b0); send(64'd3, 1'b0); send(64'd8, 1'b0);
        chk("u_no_valid_early", 64'(out_valid[0]), 64'd0);
        send(64'd2, 1'b0);
        chk("u_latency", 64'(out_valid[0]), 64'd1);
        chk("u_count", 64'(frame_count[0]), 64'd8);
        recv(0, 64'd1, 1'b0, "u0"); recv(0, 64'd2, 1'b0, "u1");
        recv(0, 64'd3, 1'b0, "u2"); recv(0, 64'd3, 1'b0, "u3");
        recv(0, 64'd5, 1'b0, "u4"); recv(0, 64'd7, 1'b0, "u5");
        recv(0, 64'd8, 1'b0, "u6"); recv(0, 64'd9, 1'b1, "u7");
        chk("u_count_clear", 64'(frame_count[0]), 64'd0);

        // Signed descending; direction is latched with the first value only.
        descend = 1'b1;
        send(64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        descend = 1'b0;
        send(64'd10, 1'b0); send(64'd0, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFC, 1'b0); send(64'd3, 1'b1);
        chk("s_count", 64'(frame_count[1]), 64'd5);
        recv(1, 64'd10, 1'b0, "s0"); recv(1, 64'd3, 1'b0, "s1");
        recv(1, 64'd0, 1'b0, "s2");
        recv(1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, "s3");
        recv(1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, "s4");

        // Binary64 total order ascending.
        send(64'h0000_0000_0000_0000, 1'b0);
        send(64'h8000_0000_0000_0000, 1'b0);
        send(64'hFFF0_0000_0000_0000, 1'b0);
        send(64'h3FF8_0000_0000_0000, 1'b0);
        send(64'h7FF8_0000_0000_0000, 1'b0);
        send(64'hC000_0000_0000_0000, 1'b1);
        recv(2, 64'hFFF0_0000_0000_0000, 1'b0, "f0");
        recv(2, 64'hC000_0000_0000_0000, 1'b0, "f1");
        recv(2, 64'h8000_0000_0000_0000, 1'b0, "f2");
        recv(2, 64'h0000_0000_0000_0000, 1'b0, "f3");
        recv(2, 64'h3FF8_0000_0000_0000, 1'b0, "f4");
        recv(2, 64'h7FF8_0000_0000_0000, 1'b1, "f5");

        // Backpressure: 3 stalled cycles, then ready alternates.
        out_ready = 1'b0;
        send(64'd4, 1'b0); send(64'd2, 1'b0); send(64'd6, 1'b1);
        step(1'b0, 64'd2, 1'b0); step(1'b0, 64'd2, 1'b0); step(1'b0, 64'd2, 1'b0);
        step(1'b1, 64'd2, 1'b0);
        step(1'b0, 64'd4, 1'b0); step(1'b1, 64'd4, 1'b0);
        step(1'b0, 64'd6, 1'b1); step(1'b1, 64'd6, 1'b1);
        chk("bp_done_valid", 64'(out_valid[0]), 64'd0);
        out_ready = 1'b1;

        // Single-value frame, next frame immediately after the handshake.
        send(64'd7, 1'b1);
        chk("single_count", 64'(frame_count[0]), 64'd1);
        recv(0, 64'd7, 1'b1, "single");
        send(64'd9, 1'b1);
        recv(0, 64'd9, 1'b1, "single_next");

        // Reset mid-FILL discards the partial frame.
        send(64'd50, 1'b0); send(64'd40, 1'b0); send(64'd30, 1'b0);
        pulse_reset();
        send(64'd20, 1'b0); send(64'd10, 1'b1);
        chk("rf_count", 64'(frame_count[0]), 64'd2);
        recv(0, 64'd10, 1'b0, "rf0"); recv(0, 64'd20, 1'b1, "rf1");

        // Reset mid-DRAIN.
        send(64'd3, 1'b0); send(64'd1, 1'b0); send(64'd2, 1'b1);
        recv(0, 64'd1, 1'b0, "rd0");
        pulse_reset();
        send(64'd8, 1'b0); send(64'd6, 1'b1);
        recv(0, 64'd6, 1'b0, "rd1"); recv(0, 64'd8, 1'b1, "rd2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/order_stream_sorter.md
Name: order_stream_sorter

Overview:
- Parametrised successor to the single-comparator ordering block.
- Accepts a frame of up to DEPTH values over a valid/ready stream and sorts them by insertion as they arrive, one value per cycle.
- Emits the sorted frame over a second valid/ready stream.
- Sits between DSP producers (per-bin magnitudes, peak candidates) and consumers that need ranked output; compare mode selectable for unsigned, signed or IEEE-754 double keys.

Parameters:
- WIDTH, 64, key/data width in bits (≥2; must be 64 when MODE=2).
- DEPTH, 8, maximum values per frame (≥2).
- MODE, 2, compare mode: 0 unsigned, 1 two's-complement signed, 2 IEEE-754 binary64 total order.

Ports:
- clock, input, 1, sole clock; all state rising-edge.
- reset, input, 1, asynchronous, active-low; asserting clears all state, deassertion synchronous to clock.
- descend, input, 1, sort direction (1 = descending); sampled with the first accepted value of a frame.
- in_valid, input, 1, upstream value valid.
- in_ready, output, 1, block can accept a value.
- in_data, input, WIDTH, value to sort.
- in_last, input, 1, final value of the frame.
- out_valid, output, 1, sorted value valid.
- out_ready, input, 1, downstream accepts.
- out_data, output, WIDTH, sorted value.
- out_last, output, 1, final sorted value of the frame.
- frame_count, output, clog2(DEPTH+1), number of values held in the current frame.

Behaviour:
- Reset values: state=FILL, count=0, rd_ptr=0, dir=0, all slots 0. Outputs: in_ready=1, out_valid=0, out_last=0, out_data=0, frame_count=0. Asserting reset mid-frame discards the frame.
- FILL state:
  - in_ready=1, out_valid=0.
  - On each in_valid&&in_ready, the value is inserted into slot array S[0..count-1] in the same cycle; count increments.
  - Insertion position p = number of slots k<count with !before(new, S[k]). Slots ≥p shift up by one; S[p]=new.
  - Ordering is stable: equal keys keep arrival order.
  - before(a,b) = lt(a,b) when dir=0, lt(b,a) when dir=1.
  - dir loads from descend when count==0 at acceptance and holds for the rest of the frame.
- Frame end: accepting a value with in_last=1, or the value that makes count==DEPTH, moves state to DRAIN next cycle. in_last is ignored beyond DEPTH, because the DEPTH-th value always closes the frame.
- DRAIN state:
  - in_ready=0, out_valid=1, out_data=S[rd_ptr], out_last=(rd_ptr==count-1).
  - On out_valid&&out_ready, rd_ptr increments.
  - On the handshake with out_last=1: state→FILL, count=0, rd_ptr=0 next cycle.
  - No overlap between frames: the next frame's first value is accepted at the earliest one cycle after the last output handshake.
- Latency: first sorted value is valid the cycle after the closing input handshake. Throughput is one value/cycle in each phase.
- Backpressure: out_data/out_last stay stable while out_valid&&!out_ready.
- frame_count = count; it holds through DRAIN and clears on return to FILL.
- Compare lt(a,b):
  - MODE 0: unsigned a<b.
  - MODE 1: signed a<b.
  - MODE 2: map key k → (k[63] ? ~k : k ^ 1<<63), then unsigned compare. This gives total order −NaN < −Inf < … < −0 < +0 < … < +Inf < +NaN. −0 sorts strictly before +0.
- Single-value frame (in_last on first value) is legal: DRAIN emits one value with out_last=1.

Decomposition:
- Shared package order_pkg:
  - MODE_UNSIGNED/MODE_SIGNED/MODE_FLOAT64 constants.
  - FILL/DRAIN state encoding.
  - float64 sign/total-order key mapping function.
- Sub-module order_less_than (WIDTH, MODE): purely combinational lt(a,b), instantiated DEPTH times, one per slot, comparing in_data against S[k]. Direction swap is done outside the sub-module.

Test Plan:
- MODE=0, DEPTH=8, ascend: send 5,3,9,1,7,3,8,2 (no in_last) → out 1,2,3,3,5,7,8,9, out_last on 9, first out_valid one cycle after 8th accept.
- MODE=1, descend=1: send −4,10,0,−4,3 with in_last on 3 → out 10,3,0,−4,−4; the two −4 values tagged in upper bits (e.g. WIDTH=16) must appear in arrival order; frame_count=5.
- MODE=2: send +0.0, −0.0, −Inf, 1.5, +NaN(0x7FF8…0), −2.0 with in_last → out −Inf, −2.0, −0.0, +0.0, 1.5, +NaN.
- Backpressure: during DRAIN, hold out_ready=0 for 3 cycles, then toggle every other cycle → out_data/out_last stable while stalled; no value lost or duplicated; in_ready stays 0 throughout DRAIN.
- Single-value frame (7 with in_last) → one output 7 with out_last=1; then an immediate new frame is accepted the cycle after that handshake.
- Reset mid-operation: assert reset after 3 values in FILL, and again mid-DRAIN → next cycle in_ready=1, out_valid=0, frame_count=0; the following frame sorts correctly with no stale slots.
